neuron_potential_accum: RTL and testbench
=========================================

// Module: neuron_potential_accum
// PURPOSE
//  Downstream stage of the 4-input CSA weight adder: takes its 16-bit per-event summed contribution, integrates it into
//  a saturating membrane potential with shift-based leak, compares against a runtime threshold, emits a 1-cycle spike
//  and enforces a refractory period. One instance per neuron in the ODESA layer; spikes feed the layer event arbiter.
// PARAMETERS
//  P_SUM_WIDTH     16  width of incoming summed contribution (adder input width + 2)
//  P_POT_WIDTH     20  membrane potential / threshold width; must be > P_SUM_WIDTH
//  P_LEAK_SHIFT    4   leak per tick = pot >> P_LEAK_SHIFT (min 1 when pot > 0)
//  P_REFRAC_CYC    8   refractory cycles after a spike; 0 allowed (no refractory)
//  P_CNT_WIDTH     16  spike counter width
// PORTS
//  i_clk         in   1            single clock, all logic rising-edge
//  i_rst_n       in   1            synchronous, active-low reset
//  i_sum_valid   in   1            i_sum holds a contribution
//  i_sum         in   P_SUM_WIDTH  unsigned contribution from adder o_s
//  o_sum_ready   out  1            block can accept a contribution this cycle
//  i_leak_tick   in   1            1-cycle decay strobe from global timebase
//  i_threshold   in   P_POT_WIDTH  unsigned firing threshold, sampled on each accept
//  o_potential   out  P_POT_WIDTH  registered membrane potential
//  o_spike       out  1            1-cycle spike pulse
//  o_refrac      out  1            high while in refractory
//  o_spike_cnt   out  P_CNT_WIDTH  spikes since reset, wraps
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge, any state): state=IDLE, o_potential=0, o_spike=0, o_refrac=0, o_spike_cnt=0,
//   refractory counter=0, o_sum_ready=1 from first cycle after reset. Mid-operation reset discards everything.
//  Accept = i_sum_valid & o_sum_ready. o_sum_ready = 1 in IDLE/ACC, 0 in FIRE/REFR (backpressure, no drop).
//  Update (IDLE/ACC): leak_v = tick ? (pot==0 ? 0 : max(pot>>P_LEAK_SHIFT,1)) : 0;
//   pot_next = sat(pot - leak_v + (accept ? zero-ext(i_sum) : 0)), saturate at 2^P_POT_WIDTH-1, never below 0.
//   Simultaneous tick+accept: leak applied to old pot, then sum added, same cycle.
//  Latency: accepted sum visible on o_potential the next cycle; o_spike asserted that same next cycle if fired.
//  States (2-bit, localparams):
//   IDLE  pot==0. accept & pot_next>=thr -> FIRE; accept & pot_next>0 -> ACC; else IDLE.
//   ACC   pot>0.  accept & pot_next>=thr -> FIRE; pot_next==0 -> IDLE; else ACC.
//         Leak-only cycles never fire (threshold checked only on accept).
//   FIRE  1 cycle: o_spike=1, o_potential = pot_next that crossed, o_spike_cnt += 1 (wrap).
//         -> REFR with counter=P_REFRAC_CYC, or -> IDLE if P_REFRAC_CYC==0. o_potential cleared to 0 on exit.
//   REFR  o_refrac=1, pot held 0, ticks ignored, counter decrements; counter==1 -> IDLE.
//  Exactly P_REFRAC_CYC cycles with o_refrac=1; o_sum_ready re-asserts the cycle after the last refractory cycle.
//  i_threshold==0: first accept (even i_sum=0) fires. Saturated pot >= any threshold -> fires.
//  Fire compare: unsigned, >=, against i_threshold sampled in the accept cycle.
// STRUCTURE
//  Shared package odesa_pkg: state localparams (ST_IDLE/ST_ACC/ST_FIRE/ST_REFR), P_POT_WIDTH/P_SUM_WIDTH
//   defaults, saturation max constant.
//  One sub-module: neuron_leak_sat (combinational: pot, sum, tick, accept -> saturated pot_next);
//   FSM, refractory counter and spike counter in top.
// TESTING (P_LEAK_SHIFT=4, P_REFRAC_CYC=8, P_POT_WIDTH=20 unless stated)
//  1 Reset: hold i_rst_n=0 3 cycles mid-ACC (pot=500) -> all outputs 0, ready=1 next cycle.
//  2 Accumulate/fire: thr=1000, sums 400,400,300 back-to-back -> pot 400,800; 3rd: o_spike=1, o_potential=1100,
//    cnt=1, then 8 cycles o_refrac=1, ready=0; a sum held valid during REFR is accepted on first IDLE cycle.
//  3 Leak: pot=160, 3 ticks no accept -> 150,141,133; pot=5 tick -> 4; pot=0 tick -> 0, stays IDLE.
//  4 Simultaneous: pot=320, tick+accept sum 100, thr=500 -> pot=400, no spike; next sum 100 -> spike.
//  5 Saturation: thr=0xFFFFF, repeated sums 0xFFFF -> pot caps at 0xFFFFF, fires on cap; thr=0 with sum 0 -> fires.
//  6 Refractory 0: P_REFRAC_CYC=0, cross thr -> FIRE 1 cycle then IDLE, ready low exactly 1 cycle; 65536 spikes -> cnt wraps to 0.

Source files
------------

// File: rtl/odesa_pkg.sv
// Shared definitions for the ODESA neuron datapath.
//  - default widths for the summed contribution and the membrane potential
//  - 2-bit neuron state encodings
//  - saturation ceiling of the potential at its default width
package odesa_pkg;

  localparam int SUM_WIDTH_DEF = 16;
  localparam int POT_WIDTH_DEF = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;  // potential is zero
  localparam logic [1:0] ST_ACC  = 2'd1;  // potential is non-zero, integrating
  localparam logic [1:0] ST_FIRE = 2'd2;  // single spike cycle
  localparam logic [1:0] ST_REFR = 2'd3;  // refractory, input blocked

  localparam logic [POT_WIDTH_DEF-1:0] POT_SAT_MAX = '1;

endpackage

// File: rtl/neuron_leak_sat.sv
// Combinational next-potential computation for one neuron.
//  pot       in   current membrane potential
//  sum       in   contribution to add (zero-extended)
//  tick      in   apply one leak step this cycle
//  accept    in   add sum this cycle
//  pot_next  out  pot - leak + sum, clamped to [0, 2^P_POT_WIDTH-1]
// Leak is pot >> P_LEAK_SHIFT, raised to 1 whenever pot is non-zero so a small
// potential still decays to zero. Leak never exceeds pot, so the subtraction
// cannot underflow; only the addition needs a carry bit for saturation.
module neuron_leak_sat #(
  parameter int P_SUM_WIDTH  = 16,
  parameter int P_POT_WIDTH  = 20,
  parameter int P_LEAK_SHIFT = 4
) (
  input  logic [P_POT_WIDTH-1:0] pot,
  input  logic [P_SUM_WIDTH-1:0] sum,
  input  logic                   tick,
  input  logic                   accept,
  output logic [P_POT_WIDTH-1:0] pot_next
);

  localparam int EXT_W = P_POT_WIDTH + 1;

  logic [P_POT_WIDTH-1:0] shifted;
  logic [P_POT_WIDTH-1:0] leak;
  logic [P_POT_WIDTH-1:0] leaked;
  logic [EXT_W-1:0]       total;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    shifted = pot >> P_LEAK_SHIFT;
    leak    = '0;
    if (tick && (pot != '0)) begin
      leak = (shifted == '0) ? P_POT_WIDTH'(1) : shifted;
    end
    leaked   = pot - leak;
    total    = {1'b0, leaked} + (accept ? EXT_W'(sum) : EXT_W'(0));
    pot_next = total[P_POT_WIDTH] ? '1 : total[P_POT_WIDTH-1:0];
  end

endmodule

// File: rtl/neuron_potential_accum.sv
// Membrane-potential integrator for one ODESA neuron.
//  i_clk / i_rst_n      clock, synchronous active-low reset
//  i_sum_valid / i_sum  contribution from the CSA weight adder
//  o_sum_ready          contribution accepted when high (low in FIRE/REFR)
//  i_leak_tick          decay strobe from the global timebase
//  i_threshold          firing threshold, compared on each accepted sum
//  o_potential          registered membrane potential
//  o_spike              1-cycle spike pulse (state FIRE)
//  o_refrac             high for P_REFRAC_CYC cycles after a spike
//  o_spike_cnt          wrapping count of spikes since reset
// Threshold is only evaluated on accept, so leak-only cycles never fire.
module neuron_potential_accum
  import odesa_pkg::*;
#(
  parameter int P_SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int P_POT_WIDTH  = POT_WIDTH_DEF,
  parameter int P_LEAK_SHIFT = 4,
  parameter int P_REFRAC_CYC = 8,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sum_valid,
  input  logic [P_SUM_WIDTH-1:0] i_sum,
  output logic                   o_sum_ready,
  input  logic                   i_leak_tick,
  input  logic [P_POT_WIDTH-1:0] i_threshold,
  output logic [P_POT_WIDTH-1:0] o_potential,
  output logic                   o_spike,
  output logic                   o_refrac,
  output logic [P_CNT_WIDTH-1:0] o_spike_cnt
);

  // Wide enough to hold P_REFRAC_CYC; one bit minimum when refractory is off.
  localparam int RC_W = (P_REFRAC_CYC < 1) ? 1 : $clog2(P_REFRAC_CYC + 1);

  logic [1:0]             state;
  logic [RC_W-1:0]        refrac_cnt;
  logic [P_POT_WIDTH-1:0] pot;
  logic [P_POT_WIDTH-1:0] pot_next;
  logic [P_CNT_WIDTH-1:0] spike_cnt;
  logic                   accept;
  logic                   fire;

  neuron_leak_sat #(
    .P_SUM_WIDTH (P_SUM_WIDTH),
    .P_POT_WIDTH (P_POT_WIDTH),
    .P_LEAK_SHIFT(P_LEAK_SHIFT)
  ) u_leak_sat (
    .pot     (pot),
    .sum     (i_sum),
    .tick    (i_leak_tick),
    .accept  (accept),
    .pot_next(pot_next)
  );

  assign o_sum_ready = (state == ST_IDLE) || (state == ST_ACC);
  assign accept      = i_sum_valid && o_sum_ready;
  assign fire        = accept && (pot_next >= i_threshold);

  assign o_potential = pot;
  assign o_spike     = (state == ST_FIRE);
  assign o_refrac    = (state == ST_REFR);
  assign o_spike_cnt = spike_cnt;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      pot        <= '0;
      refrac_cnt <= '0;
      spike_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          pot <= pot_next;
          if (fire) begin
            state     <= ST_FIRE;
            spike_cnt <= spike_cnt + P_CNT_WIDTH'(1);
          end else if (pot_next == '0) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_FIRE: begin
          // The crossing potential is shown for exactly the spike cycle.
          pot <= '0;
          if (P_REFRAC_CYC == 0) begin
            state <= ST_IDLE;
          end else begin
            state      <= ST_REFR;
            refrac_cnt <= RC_W'(P_REFRAC_CYC);
          end
        end
        ST_REFR: begin
          pot        <= '0;
          refrac_cnt <= refrac_cnt - RC_W'(1);
          if (refrac_cnt == RC_W'(1)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_potential_accum.sv
// Self-checking bench for neuron_potential_accum.
// Instance a: default parameters (refractory 8). Instance b: refractory 0 and
// an 8-bit spike counter so counter wrap is reachable in a short run.
module tb_neuron_potential_accum;
  import odesa_pkg::*;

  localparam int SW      = 16;
  localparam int PW      = 20;
  localparam int CW      = 16;
  localparam int B_CW    = 8;
  localparam int REFRAC  = 8;
  localparam int LEAK_SH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sum_valid, sum_ready, leak_tick, spike, refrac;
  logic [SW-1:0] sum;
  logic [PW-1:0] threshold, potential;
  logic [CW-1:0] spike_cnt;

  logic            b_sum_valid, b_sum_ready, b_leak_tick, b_spike, b_refrac;
  logic [SW-1:0]   b_sum;
  logic [PW-1:0]   b_threshold, b_potential;
  logic [B_CW-1:0] b_spike_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  neuron_potential_accum #(
    .P_SUM_WIDTH(SW), .P_POT_WIDTH(PW), .P_LEAK_SHIFT(LEAK_SH),
    .P_REFRAC_CYC(REFRAC), .P_CNT_WIDTH(CW)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sum_valid(sum_valid), .i_sum(sum),
    .o_sum_ready(sum_ready), .i_leak_tick(leak_tick), .i_threshold(threshold),
    .o_potential(potential), .o_spike(spike), .o_refrac(refrac),
    .o_spike_cnt(spike_cnt)
  );

  neuron_potential_accum #(
    .P_SUM_WIDTH(SW), .P_POT_WIDTH(PW), .P_LEAK_SHIFT(LEAK_SH),
    .P_REFRAC_CYC(0), .P_CNT_WIDTH(B_CW)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sum_valid(b_sum_valid), .i_sum(b_sum),
    .o_sum_ready(b_sum_ready), .i_leak_tick(b_leak_tick), .i_threshold(b_threshold),
    .o_potential(b_potential), .o_spike(b_spike), .o_refrac(b_refrac),
    .o_spike_cnt(b_spike_cnt)
  );

  // Behavioural reference for instance a.
  longint m_pot;
  bit     m_spike;
  int     m_refrac_left;
  int     m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; sum_valid = 1'b0; leak_tick = 1'b0;
    b_sum_valid = 1'b0; b_leak_tick = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] e_pot, input logic e_spk,
                         input logic e_rf, input logic e_rdy, input logic [31:0] e_cnt);
    check({tag, ".pot"},    32'(potential), e_pot);
    check({tag, ".spike"},  32'(spike),     32'(e_spk));
    check({tag, ".refrac"}, 32'(refrac),    32'(e_rf));
    check({tag, ".ready"},  32'(sum_ready), 32'(e_rdy));
    check({tag, ".cnt"},    32'(spike_cnt), e_cnt);
  endtask

  task automatic model_reset();
    m_pot = 0; m_spike = 0; m_refrac_left = 0; m_cnt = 0;
  endtask

  // Advance the reference by one clock given this cycle's inputs.
  task automatic model_step(input bit v, input longint s, input bit t, input longint thr);
    longint leak, p;
    if (m_spike) begin
      m_spike = 0;
      m_pot = 0;
      m_refrac_left = REFRAC;
    end else if (m_refrac_left > 0) begin
      m_refrac_left--;
    end else begin
      leak = 0;
      if (t && m_pot > 0) leak = ((m_pot >> LEAK_SH) == 0) ? 1 : (m_pot >> LEAK_SH);
      p = m_pot - leak + (v ? s : 0);
      if (p > longint'(POT_SAT_MAX)) p = longint'(POT_SAT_MAX);
      if (v && p >= thr) begin
        m_spike = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      m_pot = p;
    end
  endtask

  initial begin
    bit            rv, rt;
    logic [SW-1:0] rs;
    logic [PW-1:0] rth;

    rst_n = 1'b0; sum_valid = 1'b0; sum = '0; leak_tick = 1'b0; threshold = 20'd1000;
    b_sum_valid = 1'b0; b_sum = '0; b_leak_tick = 1'b0; b_threshold = '0;
    repeat (3) step();
    check_a("por", 0, 0, 0, 1, 0);
    rst_n = 1'b1;

    // Reset held mid-accumulation discards the potential.
    sum_valid = 1'b1; sum = 16'd500; step(); sum_valid = 1'b0;
    check_a("pre_rst", 500, 0, 0, 1, 0);
    rst_n = 1'b0;
    repeat (3) step();
    check_a("rst_mid", 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    step();
    check_a("rst_rel", 0, 0, 0, 1, 0);

    // Accumulate to fire, refractory, held sum accepted afterwards.
    threshold = 20'd1000; sum_valid = 1'b1;
    sum = 16'd400; step(); check_a("acc1", 400, 0, 0, 1, 0);
    sum = 16'd400; step(); check_a("acc2", 800, 0, 0, 1, 0);
    sum = 16'd300; step(); check_a("fire", 1100, 1, 0, 0, 1);
    sum = 16'd77;
    for (int i = 0; i < REFRAC; i++) begin
      step(); check_a("refr", 0, 0, 1, 0, 1);
    end
    step(); check_a("refr_exit", 0, 0, 0, 1, 1);
    step(); sum_valid = 1'b0; check_a("held_sum", 77, 0, 0, 1, 1);

    // Leak only.
    pulse_reset();
    sum_valid = 1'b1; sum = 16'd160; step(); sum_valid = 1'b0;
    leak_tick = 1'b1;
    step(); check_a("leak1", 150, 0, 0, 1, 0);
    step(); check_a("leak2", 141, 0, 0, 1, 0);
    step(); check_a("leak3", 133, 0, 0, 1, 0);
    leak_tick = 1'b0;
    pulse_reset();
    sum_valid = 1'b1; sum = 16'd5; step(); sum_valid = 1'b0;
    leak_tick = 1'b1; step(); leak_tick = 1'b0;
    check_a("leak_min", 4, 0, 0, 1, 0);
    pulse_reset();
    leak_tick = 1'b1; step(); leak_tick = 1'b0;
    check_a("leak_zero", 0, 0, 0, 1, 0);

    // Simultaneous tick and accept.
    pulse_reset();
    threshold = 20'd500;
    sum_valid = 1'b1; sum = 16'd320; step();
    leak_tick = 1'b1; sum = 16'd100; step(); leak_tick = 1'b0;
    check_a("simul", 400, 0, 0, 1, 0);
    sum = 16'd100; step(); sum_valid = 1'b0;
    check_a("simul_fire", 500, 1, 0, 0, 1);

    // Saturation and zero threshold.
    pulse_reset();
    threshold = 20'hFFFFF; sum_valid = 1'b1; sum = 16'hFFFF;
    for (int i = 1; i <= 16; i++) begin
      step(); check_a("sat_ramp", 32'(i * 65535), 0, 0, 1, 0);
    end
    step(); sum_valid = 1'b0;
    check_a("sat_fire", 32'hFFFFF, 1, 0, 0, 1);
    pulse_reset();
    threshold = '0; sum_valid = 1'b1; sum = '0; step(); sum_valid = 1'b0;
    check_a("thr_zero", 0, 1, 0, 0, 1);

    // Refractory disabled: ready low for the spike cycle only; counter wraps.
    pulse_reset();
    b_threshold = 20'd100; b_sum_valid = 1'b1; b_sum = 16'd150; step(); b_sum_valid = 1'b0;
    check("b_fire.spike", 32'(b_spike), 1);
    check("b_fire.pot", 32'(b_potential), 150);
    check("b_fire.ready", 32'(b_sum_ready), 0);
    check("b_fire.cnt", 32'(b_spike_cnt), 1);
    step();
    check("b_exit.spike", 32'(b_spike), 0);
    check("b_exit.ready", 32'(b_sum_ready), 1);
    check("b_exit.refrac", 32'(b_refrac), 0);
    check("b_exit.pot", 32'(b_potential), 0);
    b_threshold = '0; b_sum = '0; b_sum_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
      if (i == 100) check("b_wrap_mid.cnt", 32'(b_spike_cnt), 102);
      step();
    end
    b_sum_valid = 1'b0;
    check("b_wrap.cnt", 32'(b_spike_cnt), 0);
    check("b_wrap.ready", 32'(b_sum_ready), 1);

    // Randomized traffic against the reference model.
    pulse_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 1) == 1);
      rs  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2000));
      rt  = ($urandom_range(0, 3) == 0);
      rth = ($urandom_range(0, 9) == 0) ? 20'd0 : 20'($urandom_range(0, 6000));
      sum_valid = rv; sum = rs; leak_tick = rt; threshold = rth;
      model_step(rv, longint'(rs), rt, longint'(rth));
      step();
      check_a("rand", 32'(m_pot), m_spike, (m_refrac_left > 0),
              (!m_spike && m_refrac_left == 0), 32'(m_cnt));
    end
    sum_valid = 1'b0; leak_tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
